// File: rtl/reg_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : rf_mux32
// Purpose  : Single-bit 32:1 multiplexer. One instance per bit lane per read
//            port of the register file.
// Revision : 1.0 - initial release
// ============================================================================
module rf_mux32 (
    input  logic [31:0] d_i,
    input  logic [4:0]  sel_i,
    output logic        y_o
);

    assign y_o = d_i[sel_i];

endmodule

// ============================================================================
// Module   : reg_file_32x32
// Purpose  : 32 x WIDTH MIPS32 general-purpose register file. One synchronous
//            write port, two combinational read ports built from per-bit
//            32:1 muxes, optional same-cycle write->read forwarding.
//            Register 0 is hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_32x32 #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    // Only registers 1..31 hold state; index 0 is a constant zero lane.
    logic [WIDTH-1:0] regs_q [1:31];
    logic [WIDTH-1:0] regs_d [1:31];

    // Bit b of every register, gathered as the data input of lane b's muxes.
    logic [31:0]      lane_w [WIDTH];

    logic [WIDTH-1:0] mux1_w;
    logic [WIDTH-1:0] mux2_w;
    logic             fwd1_w;
    logic             fwd2_w;

    // Next-state: only the addressed register takes the write data.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (waddr == 5'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Storage update; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Transpose registers into per-bit mux inputs; input 0 is tied low.
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            lane_w[b] = '0;
            for (int r = 1; r < 32; r++) begin
                lane_w[b][r] = regs_q[r][b];
            end
        end
    end

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            rf_mux32 u_mux_rd1 (
                .d_i   (lane_w[b]),
                .sel_i (raddr1),
                .y_o   (mux1_w[b])
            );
            rf_mux32 u_mux_rd2 (
                .d_i   (lane_w[b]),
                .sel_i (raddr2),
                .y_o   (mux2_w[b])
            );
        end
    endgenerate

    // Forwarding is only legal for a real write: no reset, non-zero target.
    generate
        if (BYPASS) begin : g_bypass
            assign fwd1_w = we && !rst && (waddr != 5'd0) && (waddr == raddr1);
            assign fwd2_w = we && !rst && (waddr != 5'd0) && (waddr == raddr2);
        end else begin : g_no_bypass
            assign fwd1_w = 1'b0;
            assign fwd2_w = 1'b0;
        end
    endgenerate

    assign rdata1 = fwd1_w ? wdata : mux1_w;
    assign rdata2 = fwd2_w ? wdata : mux2_w;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_32x32
// Purpose  : Self-checking bench for reg_file_32x32. Two instances share the
//            same stimulus, one with forwarding and one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_32x32;

    typedef struct {
        logic [31:0] b1_p1;
        logic [31:0] b1_p2;
        logic [31:0] b0_p1;
        logic [31:0] b0_p2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;

    logic [31:0] model [32];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    reg_file_32x32 #(.WIDTH(32), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b1), .rdata2(rd2_b1)
    );

    reg_file_32x32 #(.WIDTH(32), .BYPASS(1'b0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b0), .rdata2(rd2_b0)
    );

    // Reference read: register value, forwarded write data when enabled.
    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (byp && we && !rst && (waddr == ra)) return wdata;
        return model[ra];
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        e.b1_p1 = a; e.b1_p2 = b; e.b0_p1 = c; e.b0_p2 = d;
        sb.push_back(e);
    endtask

    task automatic push_model();
        push_exp(exp_rd(1'b1, raddr1), exp_rd(1'b1, raddr2),
                 exp_rd(1'b0, raddr1), exp_rd(1'b0, raddr2));
    endtask

    // Advance one edge and mirror the register update in the model.
    task automatic edge_step();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        edge_step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFF_FFFF);
        raddr1 = 5'd3; raddr2 = 5'd31;
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL reset_preload got=%h %h %h %h want=%h %h %h %h",
                     rd1_b1, rd2_b1, rd1_b0, rd2_b0, e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2);
        end
        rst = 1'b1;
        edge_step();
        push_exp(32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL reset_held got=%h %h %h %h want=0", rd1_b1, rd2_b1, rd1_b0, rd2_b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            push_exp(32'h0, 32'h0, 32'h0, 32'h0);
            #2;
            e = sb.pop_front(); total++;
            if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
                bad++;
                $display("FAIL reset_clear idx=%0d got=%h %h %h %h want=0",
                         i, rd1_b1, rd2_b1, rd1_b0, rd2_b0);
            end
            edge_step();
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        write_reg(5'd5, 32'hDEAD_BEEF);
        raddr1 = 5'd5; raddr2 = 5'd5;
        push_exp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL write_read got=%h %h %h %h want=%h",
                     rd1_b1, rd2_b1, rd1_b0, rd2_b0, e.b1_p1);
        end
        edge_step();
        raddr1 = 5'd4; raddr2 = 5'd6;
        push_exp(32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL write_neighbours got=%h %h %h %h want=0",
                     rd1_b1, rd2_b1, rd1_b0, rd2_b0);
        end
        edge_step();
    endtask

    task automatic test_zero();
        exp_t e;
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
        raddr1 = 5'd0; raddr2 = 5'd0;
        for (int ph = 0; ph < 2; ph++) begin
            push_exp(32'h0, 32'h0, 32'h0, 32'h0);
            #2;
            e = sb.pop_front(); total++;
            if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
                bad++;
                $display("FAIL zero_reg phase=%0d got=%h %h %h %h want=0",
                         ph, rd1_b1, rd2_b1, rd1_b0, rd2_b0);
            end
            edge_step();
        end
        we = 1'b0;
    endtask

    task automatic test_bypass();
        exp_t e;
        write_reg(5'd7, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
        raddr1 = 5'd5; raddr2 = 5'd7;
        push_exp(32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h1);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL bypass_pre got=%h %h %h %h want=%h %h %h %h",
                     rd1_b1, rd2_b1, rd1_b0, rd2_b0, e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2);
        end
        edge_step();
        we = 1'b0;
        push_exp(32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL bypass_post got=%h %h %h %h want=%h %h %h %h",
                     rd1_b1, rd2_b1, rd1_b0, rd2_b0, e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2);
        end
        edge_step();
    endtask

    task automatic test_reset_beats_write();
        exp_t e;
        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D;
        raddr1 = 5'd9; raddr2 = 5'd9;
        for (int ph = 0; ph < 2; ph++) begin
            push_exp(32'h0, 32'h0, 32'h0, 32'h0);
            #2;
            e = sb.pop_front(); total++;
            if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
                bad++;
                $display("FAIL rst_over_we phase=%0d got=%h %h %h %h want=0",
                         ph, rd1_b1, rd2_b1, rd1_b0, rd2_b0);
            end
            edge_step();
        end
        rst = 1'b0; we = 1'b0;
        push_exp(32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        e = sb.pop_front(); total++;
        if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
            bad++;
            $display("FAIL rst_over_we_after got=%h %h %h %h want=0",
                     rd1_b1, rd2_b1, rd1_b0, rd2_b0);
        end
        edge_step();
    endtask

    task automatic test_mux_walk();
        exp_t e;
        logic [31:0] one_hot;
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h1 << i);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            one_hot = (i == 0) ? 32'h0 : (32'h1 << i);
            push_exp(one_hot, (i == 31) ? 32'h0 : (32'h1 << (31 - i)),
                     one_hot, (i == 31) ? 32'h0 : (32'h1 << (31 - i)));
            #2;
            e = sb.pop_front(); total++;
            if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
                bad++;
                $display("FAIL mux_walk idx=%0d got=%h %h %h %h want=%h %h %h %h", i,
                         rd1_b1, rd2_b1, rd1_b0, rd2_b0, e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2);
            end
            edge_step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 60; n++) begin
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            push_model();
            #2;
            e = sb.pop_front(); total++;
            if ({rd1_b1, rd2_b1, rd1_b0, rd2_b0} !== {e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2}) begin
                bad++;
                $display("FAIL b2b n=%0d we=%b wa=%0d ra=%0d/%0d got=%h %h %h %h want=%h %h %h %h",
                         n, we, waddr, raddr1, raddr2, rd1_b1, rd2_b1, rd1_b0, rd2_b0,
                         e.b1_p1, e.b1_p2, e.b0_p1, e.b0_p2);
            end
            edge_step();
        end
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        edge_step();
        edge_step();
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_zero();
        test_bypass();
        test_reset_beats_write();
        test_mux_walk();
        test_back_to_back();
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
